// File: rtl/regif_pkg.sv
// Shared definitions for the SPI register interface: register addresses,
// FSM states, CTRL bit positions and frame/response field layout.
package regif_pkg;

    localparam logic [2:0] ADDR_ID      = 3'd0;
    localparam logic [2:0] ADDR_CTRL    = 3'd1;
    localparam logic [2:0] ADDR_PER_LO  = 3'd2;
    localparam logic [2:0] ADDR_PER_HI  = 3'd3;
    localparam logic [2:0] ADDR_WID_LO  = 3'd4;
    localparam logic [2:0] ADDR_WID_HI  = 3'd5;
    localparam logic [2:0] ADDR_PCNT    = 3'd6;
    localparam logic [2:0] ADDR_SCRATCH = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_LOAD   = 2'd3
    } regif_state_e;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_CLR       = 1;
    localparam int CTRL_ERRCLR    = 3;
    localparam int CTRL_PRESC_LSB = 4;

    // CLR and ERRCLR are action bits: they are never stored and read back 0.
    localparam logic [11:0] CTRL_STORE_MASK = 12'hFF5;

    localparam int FRM_WR       = 15;
    localparam int FRM_ADDR_MSB = 14;
    localparam int FRM_ADDR_LSB = 12;
    localparam int FRM_DATA_MSB = 11;

    localparam logic [11:0] PCNT_MAX = 12'hFFF;

endpackage

// File: rtl/regif_meas_snap.sv
// Live and shadow copies of the measurement results. The shadow is loaded
// from the live registers so a PER_LO/PER_HI/WID_* read sequence is coherent.
module regif_meas_snap (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] meas_period,
    input  logic [23:0] meas_width,
    input  logic        meas_valid,
    input  logic        snap_load,
    output logic [11:0] live_period_lo,
    output logic [11:0] shadow_period_hi,
    output logic [23:0] shadow_width
);

    logic [23:0] live_period_q;
    logic [23:0] live_width_q;
    logic [11:0] shadow_period_hi_q;
    logic [23:0] shadow_width_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            live_period_q <= '0;
            live_width_q  <= '0;
        end else if (meas_valid) begin
            live_period_q <= meas_period;
            live_width_q  <= meas_width;
        end
    end

    // PER_LO is served from the live value, so only the period high half
    // needs a shadow. A same-cycle meas_valid is not seen by the shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_period_hi_q <= '0;
            shadow_width_q     <= '0;
        end else if (snap_load) begin
            shadow_period_hi_q <= live_period_q[23:12];
            shadow_width_q     <= live_width_q;
        end
    end

    assign live_period_lo   = live_period_q[11:0];
    assign shadow_period_hi = shadow_period_hi_q;
    assign shadow_width     = shadow_width_q;

endmodule

// File: rtl/spi_regif.sv
// Register decode stage behind the 16-bit SPI slave shifter.
// Optional ACTIVE-state watchdog enabled by defining REGIF_TIMEOUT_EN.
module spi_regif
    import regif_pkg::*;
#(
    parameter logic [11:0] ID_VALUE    = 12'hA51,
    parameter int          TIMEOUT_CYC = 100000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         spi_sot,
    input  logic         spi_eot,
    input  logic [15:0]  spi_rx,
    output logic [15:0]  spi_tx,
    input  logic [23:0]  meas_period,
    input  logic [23:0]  meas_width,
    input  logic         meas_valid,
    input  logic         pulse_evt,
    output logic         ctrl_enable,
    output logic [7:0]   ctrl_prescale,
    output logic         ctrl_clear,
    output logic         err_flag,
    output regif_state_e dbg_state
);

    // Handshake: the shifter gives no back-pressure. sot/eot are single-cycle
    // strobes; spi_rx is valid only with eot, and spi_tx must be stable by the
    // next sot, which the shifter guarantees by keeping CS high >= 3 clk.

    regif_state_e state_q, state_d;

    logic        latch_frame;
    logic        exec_go;
    logic        load_go;
    logic        overrun;
    logic        timeout_hit;
    logic        timeout_err;

    logic [15:0] frame_q;
    logic [11:0] ctrl_q;
    logic        clear_q;
    logic        err_q;
    logic [11:0] pcnt_q;
    logic [11:0] scratch_q;
    logic [11:0] rdata_q;
    logic [2:0]  last_addr_q;
    logic [15:0] spi_tx_q;

    logic        frm_wr;
    logic [2:0]  frm_addr;
    logic [11:0] frm_data;
    logic [11:0] rdata_c;
    logic        ctrl_write;
    logic        snap_load;

    logic [11:0] live_period_lo;
    logic [11:0] shadow_period_hi;
    logic [23:0] shadow_width;

    assign frm_wr     = frame_q[FRM_WR];
    assign frm_addr   = frame_q[FRM_ADDR_MSB:FRM_ADDR_LSB];
    assign frm_data   = frame_q[FRM_DATA_MSB:0];
    assign ctrl_write = exec_go && frm_wr && (frm_addr == ADDR_CTRL);
    assign snap_load  = exec_go && !frm_wr && (frm_addr == ADDR_PER_LO);

`ifdef REGIF_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TO_W-1:0] to_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else if (state_q == ST_ACTIVE && state_d == ST_ACTIVE && !overrun) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end else begin
            to_cnt_q <= '0;
        end
    end

    assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A sot anywhere but IDLE is an overrun: it wins over every other action
    // in that cycle, so the pending frame never executes or loads spi_tx.
    always_comb begin
        state_d     = state_q;
        latch_frame = 1'b0;
        exec_go     = 1'b0;
        load_go     = 1'b0;
        overrun     = 1'b0;
        timeout_err = 1'b0;
        if (spi_sot && state_q != ST_IDLE) begin
            overrun = 1'b1;
            state_d = ST_ACTIVE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (spi_sot) state_d = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (spi_eot) begin
                        latch_frame = 1'b1;
                        state_d     = ST_EXEC;
                    end else if (timeout_hit) begin
                        timeout_err = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    exec_go = 1'b1;
                    state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    load_go = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rdata_c = '0;
        case (frm_addr)
            ADDR_ID:      rdata_c = ID_VALUE;
            ADDR_CTRL:    rdata_c = ctrl_q;
            ADDR_PER_LO:  rdata_c = live_period_lo;
            ADDR_PER_HI:  rdata_c = shadow_period_hi;
            ADDR_WID_LO:  rdata_c = shadow_width[11:0];
            ADDR_WID_HI:  rdata_c = shadow_width[23:12];
            ADDR_PCNT:    rdata_c = pcnt_q;
            ADDR_SCRATCH: rdata_c = scratch_q;
            default:      rdata_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q     <= '0;
            ctrl_q      <= '0;
            clear_q     <= 1'b0;
            err_q       <= 1'b0;
            scratch_q   <= '0;
            rdata_q     <= '0;
            last_addr_q <= '0;
            spi_tx_q    <= '0;
        end else begin
            clear_q <= ctrl_write && frm_data[CTRL_CLR];
            if (latch_frame) frame_q <= spi_rx;
            if (ctrl_write) ctrl_q <= frm_data & CTRL_STORE_MASK;
            if (exec_go && frm_wr && frm_addr == ADDR_SCRATCH) scratch_q <= frm_data;
            if (exec_go) begin
                rdata_q     <= rdata_c;
                last_addr_q <= frm_addr;
            end
            if (overrun || timeout_err) begin
                err_q <= 1'b1;
            end else if (ctrl_write && frm_data[CTRL_ERRCLR]) begin
                err_q <= 1'b0;
            end
            if (load_go) spi_tx_q <= {last_addr_q, err_q, rdata_q};
        end
    end

    // Clear has priority so a pulse coinciding with ctrl_clear is dropped.
    always_ff @(posedge clk) begin
        if (rst || clear_q) begin
            pcnt_q <= '0;
        end else if (pulse_evt && pcnt_q != PCNT_MAX) begin
            pcnt_q <= pcnt_q + 12'd1;
        end
    end

    regif_meas_snap u_snap (
        .clk              (clk),
        .rst              (rst),
        .meas_period      (meas_period),
        .meas_width       (meas_width),
        .meas_valid       (meas_valid),
        .snap_load        (snap_load),
        .live_period_lo   (live_period_lo),
        .shadow_period_hi (shadow_period_hi),
        .shadow_width     (shadow_width)
    );

    assign spi_tx        = spi_tx_q;
    assign ctrl_enable   = ctrl_q[CTRL_EN];
    assign ctrl_prescale = ctrl_q[CTRL_PRESC_LSB +: 8];
    assign ctrl_clear    = clear_q;
    assign err_flag      = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_spi_regif.sv
// Directed bench for spi_regif; the watchdog section runs only when
// REGIF_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYC=16).
module tb_spi_regif;
    import regif_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         spi_sot = 1'b0;
    logic         spi_eot = 1'b0;
    logic [15:0]  spi_rx = '0;
    logic [15:0]  spi_tx;
    logic [23:0]  meas_period = '0;
    logic [23:0]  meas_width = '0;
    logic         meas_valid = 1'b0;
    logic         pulse_evt = 1'b0;
    logic         ctrl_enable;
    logic [7:0]   ctrl_prescale;
    logic         ctrl_clear;
    logic         err_flag;
    regif_state_e dbg_state;

    int tests = 0;
    int fails = 0;
    int clr_cnt = 0;
    logic [15:0] r;

    spi_regif #(.ID_VALUE(12'hA51), .TIMEOUT_CYC(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .spi_sot       (spi_sot),
        .spi_eot       (spi_eot),
        .spi_rx        (spi_rx),
        .spi_tx        (spi_tx),
        .meas_period   (meas_period),
        .meas_width    (meas_width),
        .meas_valid    (meas_valid),
        .pulse_evt     (pulse_evt),
        .ctrl_enable   (ctrl_enable),
        .ctrl_prescale (ctrl_prescale),
        .ctrl_clear    (ctrl_clear),
        .err_flag      (err_flag),
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ctrl_clear) clr_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; resp is what the shifter would load at sot.
    task automatic xfer(input logic [15:0] frame, output logic [15:0] resp);
        tick();
        resp = spi_tx;
        spi_sot = 1'b1;
        tick();
        spi_sot = 1'b0;
        repeat (3) tick();
        spi_eot = 1'b1;
        spi_rx = frame;
        tick();
        spi_eot = 1'b0;
        repeat (3) tick();
    endtask

    task automatic pulse_meas(input logic [23:0] per, input logic [23:0] wid);
        meas_period = per;
        meas_width = wid;
        meas_valid = 1'b1;
        tick();
        meas_valid = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_spi_tx", 32'(spi_tx), 32'h0000);
        chk("rst_enable", 32'(ctrl_enable), 32'h0);
        chk("rst_prescale", 32'(ctrl_prescale), 32'h00);
        chk("rst_clear", 32'(ctrl_clear), 32'h0);
        chk("rst_err", 32'(err_flag), 32'h0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        // eot without sot must not execute the frame
        spi_eot = 1'b1;
        spi_rx = 16'h9FF1;
        tick();
        spi_eot = 1'b0;
        repeat (3) tick();
        chk("idle_eot_prescale", 32'(ctrl_prescale), 32'h00);
        chk("idle_eot_enable", 32'(ctrl_enable), 32'h0);
        chk("idle_eot_state", 32'(dbg_state), 32'(ST_IDLE));

        xfer(16'h0000, r);
        xfer(16'h0000, r);
        chk("id_read", 32'(r), 32'h0A51);

        xfer(16'h9AB5, r);
        xfer(16'h1000, r);
        xfer(16'h0000, r);
        chk("ctrl_read", 32'(r), 32'h2AB5);
        chk("ctrl_enable", 32'(ctrl_enable), 32'h1);
        chk("ctrl_prescale", 32'(ctrl_prescale), 32'hAB);

        pulse_meas(24'h123456, 24'hABCDEF);
        xfer(16'h2000, r);
        pulse_meas(24'hFFFFFF, 24'hFFFFFF);
        xfer(16'h3000, r);
        chk("per_lo", 32'(r), 32'h4456);
        xfer(16'h4000, r);
        chk("per_hi_shadow", 32'(r), 32'h6123);
        xfer(16'h5000, r);
        chk("wid_lo_shadow", 32'(r), 32'h8DEF);
        xfer(16'h2000, r);
        chk("wid_hi_shadow", 32'(r), 32'hAABC);
        xfer(16'h3000, r);
        chk("per_lo_new", 32'(r), 32'h4FFF);
        xfer(16'h0000, r);
        chk("per_hi_new", 32'(r), 32'h6FFF);

        xfer(16'h8FFF, r);
        xfer(16'h0000, r);
        chk("ro_write_ignored", 32'(r), 32'h0A51);
        chk("ro_write_no_err", 32'(err_flag), 32'h0);

        pulse_evt = 1'b1;
        repeat (4100) tick();
        pulse_evt = 1'b0;
        xfer(16'h6000, r);
        xfer(16'h0000, r);
        chk("pcnt_sat", 32'(r), 32'hCFFF);
        clr_cnt = 0;
        xfer(16'h9003, r);
        chk("clear_pulses", 32'(clr_cnt), 32'd1);
        chk("clear_enable", 32'(ctrl_enable), 32'h1);
        chk("clear_prescale", 32'(ctrl_prescale), 32'h00);
        xfer(16'h6000, r);
        xfer(16'h0000, r);
        chk("pcnt_cleared", 32'(r), 32'hC000);

        // second sot one clk after eot: the SCRATCH write is discarded
        tick();
        spi_sot = 1'b1;
        tick();
        spi_sot = 1'b0;
        repeat (2) tick();
        spi_eot = 1'b1;
        spi_rx = 16'hF123;
        tick();
        spi_eot = 1'b0;
        spi_sot = 1'b1;
        tick();
        spi_sot = 1'b0;
        repeat (2) tick();
        spi_eot = 1'b1;
        spi_rx = 16'h7000;
        tick();
        spi_eot = 1'b0;
        repeat (3) tick();
        chk("overrun_err", 32'(err_flag), 32'h1);
        chk("overrun_state", 32'(dbg_state), 32'(ST_IDLE));
        xfer(16'h9009, r);
        chk("overrun_resp", 32'(r), 32'hF000);
        chk("errclr", 32'(err_flag), 32'h0);
        xfer(16'h7000, r);
        chk("errclr_resp", 32'(r), 32'h2001);
        xfer(16'hF5A5, r);
        chk("scratch_pre", 32'(r), 32'hE000);
        xfer(16'h7000, r);
        chk("scratch_wr_resp", 32'(r), 32'hE000);
        xfer(16'h0000, r);
        chk("scratch_rd", 32'(r), 32'hE5A5);

`ifdef REGIF_TIMEOUT_EN
        tick();
        spi_sot = 1'b1;
        tick();
        spi_sot = 1'b0;
        repeat (20) tick();
        chk("timeout_err", 32'(err_flag), 32'h1);
        chk("timeout_state", 32'(dbg_state), 32'(ST_IDLE));
        spi_eot = 1'b1;
        spi_rx = 16'h9FF1;
        tick();
        spi_eot = 1'b0;
        repeat (3) tick();
        chk("late_eot_prescale", 32'(ctrl_prescale), 32'h00);
        chk("late_eot_state", 32'(dbg_state), 32'(ST_IDLE));
        xfer(16'h9009, r);
        chk("timeout_errclr", 32'(err_flag), 32'h0);
`endif

        // reset in the middle of a transaction, then a stray eot
        tick();
        spi_sot = 1'b1;
        tick();
        spi_sot = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        spi_eot = 1'b1;
        spi_rx = 16'h9FF1;
        tick();
        spi_eot = 1'b0;
        repeat (3) tick();
        chk("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("midrst_enable", 32'(ctrl_enable), 32'h0);
        chk("midrst_prescale", 32'(ctrl_prescale), 32'h00);
        chk("midrst_spi_tx", 32'(spi_tx), 32'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
